register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter RoB_WIDTH, default 3: width of a RoB entry index (tag).
REQ-002 SHALL have parameter REG_NUM, default 32: number of architectural registers.
REQ-003 SHALL have input clk_in, 1 bit: the single clock; all state updates on posedge.
REQ-004 SHALL have input rst_in, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have input rdy_in, 1 bit: when low, all state holds.
REQ-006 SHALL have input flush, 1 bit: mispredict flush from the RoB.
REQ-007 SHALL have inputs rs1 and rs2, 5 bits each: dispatcher read addresses.
REQ-008 SHALL have outputs rs1_value and rs2_value, 32 bits each: register value or bypassed commit data.
REQ-009 SHALL have outputs rs1_busy and rs2_busy, 1 bit each: the operand waits on a RoB entry.
REQ-010 SHALL have outputs rs1_tag and rs2_tag, RoB_WIDTH bits each: RoB index producing the operand; valid only when the matching busy is 1.
REQ-011 SHALL have input rename_en, 1 bit: dispatcher allocates a RoB entry that writes rename_rd.
REQ-012 SHALL have input rename_rd, 5 bits: destination register of the allocation.
REQ-013 SHALL have input rename_tag, RoB_WIDTH bits: RoB index of the allocation.
REQ-014 SHALL have input RF_update_en, 1 bit: RoB commit strobe.
REQ-015 SHALL have input RF_update_reg, 5 bits: committed destination register.
REQ-016 SHALL have input RF_update_index, RoB_WIDTH bits: RoB index of the committing entry.
REQ-017 SHALL have input RF_update_data, 32 bits: committed value.

Function
REQ-018 SHALL hold per register: value[31:0], busy bit, tag[RoB_WIDTH-1:0].
REQ-019 Read ports SHALL be combinational: rsN_value = value[rsN], rsN_busy = busy[rsN], rsN_tag = tag[rsN], subject to REQ-020 to REQ-022.
REQ-020 Commit bypass: if RF_update_en, RF_update_reg == rsN != 0, busy[rsN] and tag[rsN] == RF_update_index in the same cycle, the read SHALL return RF_update_data with busy 0.
REQ-021 A read SHALL never reflect a same-cycle rename; sources resolve before the destination of the same instruction, so rs1 == rename_rd returns the pre-rename mapping.
REQ-022 Register x0 SHALL always read value 0, busy 0, tag 0; writes and renames to x0 SHALL be ignored.
REQ-023 On commit (RF_update_en, reg != 0), value[reg] SHALL be set to RF_update_data at the next edge.
REQ-024 On commit, busy[reg] SHALL be cleared only if tag[reg] == RF_update_index and there is no same-cycle rename of reg; otherwise busy and tag are unchanged.
REQ-025 On rename (rename_en, rd != 0, no flush), the block SHALL set busy[rd] = 1 and tag[rd] = rename_tag at the next edge.
REQ-026 When rename and commit target the same register in the same cycle, the value SHALL be written, busy SHALL be 1 and tag SHALL equal rename_tag.
REQ-027 Flush: at the next edge all busy bits SHALL clear and all tags SHALL go to 0. A same-cycle commit value write SHALL still occur. A same-cycle rename SHALL be dropped.
REQ-028 With rdy_in low, commit, rename and flush SHALL be ignored and state SHALL hold; reads stay combinational.
REQ-029 Latency: a committed value SHALL be visible with busy 0 in the same cycle via bypass and from state one cycle later.

Reset
REQ-030 When rst_in is high at a clock edge, all values, busy bits and tags SHALL go to 0, overriding rdy_in, flush, commit and rename.
REQ-031 After reset, all read outputs SHALL be 0 until the first write.

Verification
REQ-032 Reset, then rename x5 with tag 3; next cycle read rs1=5 -> busy 1, tag 3. Commit reg 5, index 3, data 0x1234 -> same-cycle rs1_value 0x1234 with busy 0; next cycle stored value 0x1234, busy 0.
REQ-033 Rename x7 with tag 1, then x7 with tag 2, then commit reg 7, index 1, data 0xAA -> value 0xAA, busy stays 1, tag 2.
REQ-034 Same cycle: rename x9 with tag 4 and commit reg 9 (matching old tag 2) with data 0x55 -> value 0x55, busy 1, tag 4. Same cycle: rs1=9 with rename_rd=9 -> read uses the old mapping.
REQ-035 Busy x3 and x4 pending; assert flush together with commit reg 3, data 0x77, and rename x6 -> next cycle all busy 0, x3 = 0x77, x6 not busy.
REQ-036 Commit reg 0, data 0xFFFF_FFFF and rename x0 -> x0 reads 0, busy 0. With rdy_in low, commit reg 8 -> x8 unchanged.

Source files
------------

// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - dispatcher read/rename and RoB commit bundle for the register file
interface register_file_if #(
  parameter int RoB_WIDTH = 3
);
  logic [4:0]           rs1;
  logic [4:0]           rs2;
  logic [31:0]          rs1_value;
  logic [31:0]          rs2_value;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic [RoB_WIDTH-1:0] rs1_tag;
  logic [RoB_WIDTH-1:0] rs2_tag;
  logic                 rename_en;
  logic [4:0]           rename_rd;
  logic [RoB_WIDTH-1:0] rename_tag;
  logic                 RF_update_en;
  logic [4:0]           RF_update_reg;
  logic [RoB_WIDTH-1:0] RF_update_index;
  logic [31:0]          RF_update_data;

  modport master (
    output rs1, rs2, rename_en, rename_rd, rename_tag,
           RF_update_en, RF_update_reg, RF_update_index, RF_update_data,
    input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );

  modport slave (
    input  rs1, rs2, rename_en, rename_rd, rename_tag,
           RF_update_en, RF_update_reg, RF_update_index, RF_update_data,
    output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - renamed architectural register file with RoB tags and commit bypass
module register_file #(
  parameter int RoB_WIDTH = 3,
  parameter int REG_NUM   = 32
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           flush,
  register_file_if.slave bus
);
  typedef logic [RoB_WIDTH-1:0] tag_t;

  logic [31:0]        value_q [REG_NUM];
  logic [31:0]        value_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  tag_t               tag_q   [REG_NUM];
  tag_t               tag_d   [REG_NUM];

  logic commit_hit;
  logic rename_hit;
  logic rename_same_reg;

  assign commit_hit      = bus.RF_update_en && (bus.RF_update_reg != 5'd0);
  assign rename_hit      = bus.rename_en && (bus.rename_rd != 5'd0) && !flush;
  assign rename_same_reg = bus.rename_en && (bus.rename_rd == bus.RF_update_reg);

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (rdy_in) begin
      if (commit_hit) begin
        value_d[bus.RF_update_reg] = bus.RF_update_data;
        // A newer rename of the same register keeps it waiting on the newer tag.
        if ((tag_q[bus.RF_update_reg] == bus.RF_update_index) && !rename_same_reg) begin
          busy_d[bus.RF_update_reg] = 1'b0;
        end
      end
      if (rename_hit) begin
        busy_d[bus.rename_rd] = 1'b1;
        tag_d[bus.rename_rd]  = bus.rename_tag;
      end
      if (flush) begin
        busy_d = '0;
        for (int i = 0; i < REG_NUM; i++) begin
          tag_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  // Reads see pre-edge state only, so a same-cycle rename never shows up here.
  always_comb begin
    bus.rs1_value = value_q[bus.rs1];
    bus.rs1_busy  = busy_q[bus.rs1];
    bus.rs1_tag   = tag_q[bus.rs1];
    if (bus.rs1 == 5'd0) begin
      bus.rs1_value = '0;
      bus.rs1_busy  = 1'b0;
      bus.rs1_tag   = '0;
    end else if (bus.RF_update_en && (bus.RF_update_reg == bus.rs1) && busy_q[bus.rs1]
                 && (tag_q[bus.rs1] == bus.RF_update_index)) begin
      bus.rs1_value = bus.RF_update_data;
      bus.rs1_busy  = 1'b0;
    end
  end

  always_comb begin
    bus.rs2_value = value_q[bus.rs2];
    bus.rs2_busy  = busy_q[bus.rs2];
    bus.rs2_tag   = tag_q[bus.rs2];
    if (bus.rs2 == 5'd0) begin
      bus.rs2_value = '0;
      bus.rs2_busy  = 1'b0;
      bus.rs2_tag   = '0;
    end else if (bus.RF_update_en && (bus.RF_update_reg == bus.rs2) && busy_q[bus.rs2]
                 && (tag_q[bus.rs2] == bus.RF_update_index)) begin
      bus.rs2_value = bus.RF_update_data;
      bus.rs2_busy  = 1'b0;
    end
  end
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - self-checking bench for register_file against a behavioural model
module tb_register_file;
  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;
  logic flush;

  register_file_if #(.RoB_WIDTH(3)) bus ();

  register_file #(.RoB_WIDTH(3), .REG_NUM(32)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (flush),
    .bus    (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;

  // Architectural model: what each register holds, whether it waits, and on which tag.
  logic [31:0] m_val  [32];
  logic        m_busy [32];
  logic [2:0]  m_tag  [32];
  logic [31:0] nv [32];
  logic        nb [32];
  logic [2:0]  nt [32];
  logic        armed = 1'b0;

  always @(posedge clk_in) begin
    for (int i = 0; i < 32; i++) begin
      nv[i] = m_val[i];
      nb[i] = m_busy[i];
      nt[i] = m_tag[i];
    end
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        nv[i] = 32'd0;
        nb[i] = 1'b0;
        nt[i] = 3'd0;
      end
    end else if (rdy_in) begin
      if (bus.RF_update_en && bus.RF_update_reg != 5'd0) begin
        nv[bus.RF_update_reg] = bus.RF_update_data;
        if (m_tag[bus.RF_update_reg] == bus.RF_update_index
            && !(bus.rename_en && bus.rename_rd == bus.RF_update_reg))
          nb[bus.RF_update_reg] = 1'b0;
      end
      if (bus.rename_en && bus.rename_rd != 5'd0 && !flush) begin
        nb[bus.rename_rd] = 1'b1;
        nt[bus.rename_rd] = bus.rename_tag;
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) begin
          nb[i] = 1'b0;
          nt[i] = 3'd0;
        end
      end
    end
    for (int i = 0; i < 32; i++) begin
      m_val[i]  <= nv[i];
      m_busy[i] <= nb[i];
      m_tag[i]  <= nt[i];
    end
    if (rst_in) armed <= 1'b1;
  end

  task automatic check_port(input string nm, input logic [4:0] a, input logic [31:0] v,
                            input logic b, input logic [2:0] t);
    logic [31:0] ev;
    logic        eb;
    logic [2:0]  et;
    ev = m_val[a];
    eb = m_busy[a];
    et = m_tag[a];
    if (a == 5'd0) begin
      ev = 32'd0;
      eb = 1'b0;
      et = 3'd0;
    end else if (bus.RF_update_en && bus.RF_update_reg == a && m_busy[a]
                 && m_tag[a] == bus.RF_update_index) begin
      ev = bus.RF_update_data;
      eb = 1'b0;
    end
    tests++;
    if (v !== ev) begin
      fails++;
      $display("FAIL %s_value x%0d at %0t: got %h expected %h", nm, a, $time, v, ev);
    end
    tests++;
    if (b !== eb) begin
      fails++;
      $display("FAIL %s_busy x%0d at %0t: got %b expected %b", nm, a, $time, b, eb);
    end
    if (eb || a == 5'd0) begin
      tests++;
      if (t !== et) begin
        fails++;
        $display("FAIL %s_tag x%0d at %0t: got %0d expected %0d", nm, a, $time, t, et);
      end
    end
  endtask

  always @(negedge clk_in) begin
    if (armed && !rst_in) begin
      check_port("rs1", bus.rs1, bus.rs1_value, bus.rs1_busy, bus.rs1_tag);
      check_port("rs2", bus.rs2, bus.rs2_value, bus.rs2_busy, bus.rs2_tag);
    end
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus.rs1             = 5'd0;
    bus.rs2             = 5'd0;
    bus.rename_en       = 1'b0;
    bus.rename_rd       = 5'd0;
    bus.rename_tag      = 3'd0;
    bus.RF_update_en    = 1'b0;
    bus.RF_update_reg   = 5'd0;
    bus.RF_update_index = 3'd0;
    bus.RF_update_data  = 32'd0;
    flush               = 1'b0;
  endtask

  task automatic ren(input logic [4:0] rd, input logic [2:0] tg);
    bus.rename_en  = 1'b1;
    bus.rename_rd  = rd;
    bus.rename_tag = tg;
  endtask

  task automatic cmt(input logic [4:0] rg, input logic [2:0] ix, input logic [31:0] d);
    bus.RF_update_en    = 1'b1;
    bus.RF_update_reg   = rg;
    bus.RF_update_index = ix;
    bus.RF_update_data  = d;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in  = 1'b0;
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd31;
    @(negedge clk_in);
    lit("reset_rs1_value", bus.rs1_value, 32'd0);
    lit("reset_rs1_busy", {31'd0, bus.rs1_busy}, 32'd0);
    lit("reset_rs2_value", bus.rs2_value, 32'd0);

    tick(); idle(); ren(5'd5, 3'd3); bus.rs1 = 5'd5;
    @(negedge clk_in);
    lit("pre_rename_busy", {31'd0, bus.rs1_busy}, 32'd0);
    tick(); idle(); bus.rs1 = 5'd5;
    @(negedge clk_in);
    lit("x5_busy", {31'd0, bus.rs1_busy}, 32'd1);
    lit("x5_tag", {29'd0, bus.rs1_tag}, 32'd3);
    tick(); idle(); cmt(5'd5, 3'd3, 32'h1234); bus.rs1 = 5'd5;
    @(negedge clk_in);
    lit("x5_bypass_value", bus.rs1_value, 32'h1234);
    lit("x5_bypass_busy", {31'd0, bus.rs1_busy}, 32'd0);
    tick(); idle(); bus.rs1 = 5'd5;
    @(negedge clk_in);
    lit("x5_stored_value", bus.rs1_value, 32'h1234);
    lit("x5_stored_busy", {31'd0, bus.rs1_busy}, 32'd0);

    tick(); idle(); ren(5'd7, 3'd1);
    tick(); idle(); ren(5'd7, 3'd2);
    tick(); idle(); cmt(5'd7, 3'd1, 32'hAA); bus.rs1 = 5'd7;
    @(negedge clk_in);
    lit("x7_stale_no_bypass", bus.rs1_value, 32'd0);
    tick(); idle(); bus.rs1 = 5'd7;
    @(negedge clk_in);
    lit("x7_value", bus.rs1_value, 32'hAA);
    lit("x7_busy", {31'd0, bus.rs1_busy}, 32'd1);
    lit("x7_tag", {29'd0, bus.rs1_tag}, 32'd2);

    tick(); idle(); ren(5'd9, 3'd2);
    tick(); idle(); ren(5'd9, 3'd4); cmt(5'd9, 3'd2, 32'h55); bus.rs1 = 5'd9; bus.rs2 = 5'd7;
    @(negedge clk_in);
    lit("x9_old_mapping_value", bus.rs1_value, 32'h55);
    lit("x9_old_mapping_busy", {31'd0, bus.rs1_busy}, 32'd0);
    tick(); idle(); bus.rs1 = 5'd9;
    @(negedge clk_in);
    lit("x9_value", bus.rs1_value, 32'h55);
    lit("x9_busy", {31'd0, bus.rs1_busy}, 32'd1);
    lit("x9_tag", {29'd0, bus.rs1_tag}, 32'd4);

    tick(); idle(); ren(5'd3, 3'd5);
    tick(); idle(); ren(5'd4, 3'd6);
    tick(); idle(); flush = 1'b1; cmt(5'd3, 3'd5, 32'h77); ren(5'd6, 3'd7); bus.rs1 = 5'd3;
    tick(); idle(); bus.rs1 = 5'd3; bus.rs2 = 5'd4;
    @(negedge clk_in);
    lit("flush_x3_value", bus.rs1_value, 32'h77);
    lit("flush_x3_busy", {31'd0, bus.rs1_busy}, 32'd0);
    lit("flush_x4_busy", {31'd0, bus.rs2_busy}, 32'd0);
    tick(); idle(); bus.rs1 = 5'd6; bus.rs2 = 5'd9;
    @(negedge clk_in);
    lit("flush_x6_busy", {31'd0, bus.rs1_busy}, 32'd0);
    lit("flush_x9_busy", {31'd0, bus.rs2_busy}, 32'd0);

    tick(); idle(); cmt(5'd0, 3'd0, 32'hFFFF_FFFF); ren(5'd0, 3'd1);
    tick(); idle();
    @(negedge clk_in);
    lit("x0_value", bus.rs1_value, 32'd0);
    lit("x0_busy", {31'd0, bus.rs1_busy}, 32'd0);
    lit("x0_tag", {29'd0, bus.rs1_tag}, 32'd0);

    tick(); idle(); ren(5'd10, 3'd1);
    tick(); idle(); rdy_in = 1'b0; cmt(5'd8, 3'd0, 32'hBEEF); flush = 1'b1; ren(5'd8, 3'd3);
    tick(); idle(); rdy_in = 1'b1; bus.rs1 = 5'd8; bus.rs2 = 5'd10;
    @(negedge clk_in);
    lit("rdy_low_x8_value", bus.rs1_value, 32'd0);
    lit("rdy_low_x8_busy", {31'd0, bus.rs1_busy}, 32'd0);
    lit("rdy_low_x10_busy", {31'd0, bus.rs2_busy}, 32'd1);
    lit("rdy_low_x10_tag", {29'd0, bus.rs2_tag}, 32'd1);

    tick(); idle(); rst_in = 1'b1; cmt(5'd10, 3'd1, 32'h99); ren(5'd11, 3'd2);
    tick(); idle(); rst_in = 1'b0; bus.rs1 = 5'd10; bus.rs2 = 5'd11;
    @(negedge clk_in);
    lit("rst_x10_value", bus.rs1_value, 32'd0);
    lit("rst_x10_busy", {31'd0, bus.rs1_busy}, 32'd0);
    lit("rst_x11_busy", {31'd0, bus.rs2_busy}, 32'd0);
    tick(); idle(); bus.rs1 = 5'd5; bus.rs2 = 5'd7;
    @(negedge clk_in);
    lit("rst_x5_value", bus.rs1_value, 32'd0);
    lit("rst_x7_value", bus.rs2_value, 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
